// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
//   Shared types and helpers for the fractional baud/tick generator family.
//   - div_t       : {div_int, div_frac} divisor pair at the default widths
//   - OVS_DEFAULT : default oversample ratio
//   - calc_div    : derive a divisor for a clock/baud/oversample combination,
//                   rounded to the nearest 1/2^FW_DEFAULT of a cycle
// -----------------------------------------------------------------------------
package baud_pkg;

    localparam int unsigned CW_DEFAULT  = 16;
    localparam int unsigned FW_DEFAULT  = 4;
    localparam int unsigned OVS_DEFAULT = 16;

    typedef struct packed {
        logic [CW_DEFAULT-1:0] div_int;
        logic [FW_DEFAULT-1:0] div_frac;
    } div_t;

    function automatic div_t calc_div(input longint unsigned clk_hz,
                                      input longint unsigned baud,
                                      input longint unsigned ovs);
        longint unsigned den;
        longint unsigned scaled;
        div_t            d;
        den = baud * ovs;
        if (den == 0) den = 1;
        // Divisor in fixed point with FW_DEFAULT fraction bits, rounded.
        scaled     = ((clk_hz << FW_DEFAULT) + (den >> 1)) / den;
        d.div_int  = scaled[FW_DEFAULT +: CW_DEFAULT];
        d.div_frac = scaled[FW_DEFAULT-1:0];
        return d;
    endfunction

endpackage

// File: rtl/frac_baud_gen_if.sv
// -----------------------------------------------------------------------------
// frac_baud_gen_if
//   Control/status bundle of frac_baud_gen.
//   master : drives en, clr, div_wr, div_int, div_frac; sees tick, bit_tick,
//            ovs_phase, div_ack
//   slave  : the generator side (mirror of master)
// -----------------------------------------------------------------------------
interface frac_baud_gen_if
    import baud_pkg::*;
#(
    parameter int unsigned CW  = CW_DEFAULT,
    parameter int unsigned FW  = FW_DEFAULT,
    parameter int unsigned OVS = OVS_DEFAULT
);
    localparam int unsigned PW = $clog2(OVS);

    logic          en;
    logic          clr;
    logic          div_wr;
    logic [CW-1:0] div_int;
    logic [FW-1:0] div_frac;
    logic          tick;
    logic          bit_tick;
    logic [PW-1:0] ovs_phase;
    logic          div_ack;

    modport master (
        output en, clr, div_wr, div_int, div_frac,
        input  tick, bit_tick, ovs_phase, div_ack
    );

    modport slave (
        input  en, clr, div_wr, div_int, div_frac,
        output tick, bit_tick, ovs_phase, div_ack
    );

endinterface

// File: rtl/ovs_divider.sv
// -----------------------------------------------------------------------------
// ovs_divider
//   Mod-OVS oversample phase counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous return to phase 0
//   adv      : advance one phase (terminal count of the period counter)
//   phase    : current oversample index 0..OVS-1
//   wrap     : adv while at OVS-1, i.e. the phase is about to return to 0
// -----------------------------------------------------------------------------
module ovs_divider
    import baud_pkg::*;
#(
    parameter  int unsigned OVS = OVS_DEFAULT,
    localparam int unsigned PW  = $clog2(OVS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [PW-1:0] phase,
    output logic          wrap
);
    localparam logic [PW-1:0] LAST = PW'(OVS - 1);

    logic [PW-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr)
            phase_d = '0;
        else if (adv)
            phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
    end

    assign phase = phase_q;
    assign wrap  = adv & (phase_q == LAST);

endmodule

// File: rtl/frac_baud_gen.sv
// -----------------------------------------------------------------------------
// frac_baud_gen
//   Runtime-programmable oversample tick generator with fractional divisor.
//   Average tick period = max(div_int,1) + div_frac/2^FW cycles; bit_tick
//   fires on every OVS-th tick.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : frac_baud_gen_if.slave
//              en/clr       count enable / synchronous restart
//              div_wr       strobe capturing div_int/div_frac into the shadow
//              tick         registered oversample tick
//              bit_tick     registered tick at ovs_phase wrap to 0
//              ovs_phase    oversample index
//              div_ack      pulse when the shadow divisor becomes active
//   Build option FRAC_BAUD_GEN_FRAC_EN: enables the fractional accumulator.
//   Without it div_frac is ignored and every period is max(div_int,1).
// -----------------------------------------------------------------------------
module frac_baud_gen
    import baud_pkg::*;
#(
    parameter int unsigned CW      = 16,
    parameter int unsigned FW      = 4,
    parameter int unsigned OVS     = OVS_DEFAULT,
    parameter int unsigned DIV_RST = 326
) (
    input  logic           clk,
    input  logic           rst,
    frac_baud_gen_if.slave bus
);
    localparam int unsigned PW = $clog2(OVS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_int_q, act_int_d;
    logic [CW-1:0] sh_int_q, sh_int_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          bit_tick_q, bit_tick_d;
    logic          ack_q, ack_d;

    logic [CW-1:0] eff_int;
    logic [CW:0]   len_m1;
    logic          carry_cur;
    logic          term, apply, adv, wrap;
    logic [PW-1:0] phase;

`ifdef FRAC_BAUD_GEN_FRAC_EN
    logic [FW-1:0] act_frac_q, act_frac_d;
    logic [FW-1:0] sh_frac_q, sh_frac_d;
    logic [FW-1:0] acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [FW-1:0] next_frac;

    assign carry_cur = carry_q;
    // The carry sizes the period that starts now, so it uses the fraction
    // that will be active for that period (the shadow if it applies here).
    assign next_frac = apply ? sh_frac_q : act_frac_q;
`else
    logic [FW-1:0] unused_frac;

    assign carry_cur   = 1'b0;
    assign unused_frac = bus.div_frac;
`endif

    assign eff_int = (act_int_q == '0) ? CW'(1) : act_int_q;
    assign len_m1  = {1'b0, eff_int} + {{CW{1'b0}}, carry_cur} - (CW+1)'(1);
    // >= rather than ==: a divisor applied while frozen may be shorter than
    // the count already reached; the period then ends on the next enabled cycle.
    assign term    = ({1'b0, cnt_q} >= len_m1);
    assign apply   = pend_q & ~bus.clr & (~bus.en | term);
    assign adv     = bus.en & ~bus.clr & term;

    ovs_divider #(.OVS(OVS)) u_ovs (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.clr),
        .adv   (adv),
        .phase (phase),
        .wrap  (wrap)
    );

    always_comb begin
        cnt_d      = cnt_q;
        act_int_d  = act_int_q;
        sh_int_d   = sh_int_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        bit_tick_d = 1'b0;
        ack_d      = apply;
`ifdef FRAC_BAUD_GEN_FRAC_EN
        act_frac_d = act_frac_q;
        sh_frac_d  = sh_frac_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
`endif
        if (apply) begin
            act_int_d = sh_int_q;
            pend_d    = 1'b0;
`ifdef FRAC_BAUD_GEN_FRAC_EN
            act_frac_d = sh_frac_q;
`endif
        end
        // Evaluated after apply: a write coinciding with an apply stays pending.
        if (bus.div_wr) begin
            sh_int_d = bus.div_int;
            pend_d   = 1'b1;
`ifdef FRAC_BAUD_GEN_FRAC_EN
            sh_frac_d = bus.div_frac;
`endif
        end
        if (bus.clr) begin
            cnt_d = '0;
`ifdef FRAC_BAUD_GEN_FRAC_EN
            acc_d   = '0;
            carry_d = 1'b0;
`endif
        end else if (bus.en) begin
            if (term) begin
                cnt_d      = '0;
                tick_d     = 1'b1;
                bit_tick_d = wrap;
`ifdef FRAC_BAUD_GEN_FRAC_EN
                {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, next_frac};
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            act_int_q  <= CW'(DIV_RST);
            sh_int_q   <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            bit_tick_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_int_q  <= act_int_d;
            sh_int_q   <= sh_int_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            bit_tick_q <= bit_tick_d;
            ack_q      <= ack_d;
        end
    end

`ifdef FRAC_BAUD_GEN_FRAC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_frac_q <= '0;
            sh_frac_q  <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
        end else begin
            act_frac_q <= act_frac_d;
            sh_frac_q  <= sh_frac_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
        end
    end
`endif

    assign bus.tick      = tick_q;
    assign bus.bit_tick  = bit_tick_q;
    assign bus.ovs_phase = phase;
    assign bus.div_ack   = ack_q;

endmodule

// File: tb/tb_frac_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_frac_baud_gen
//   Self-checking bench for frac_baud_gen: directed scenarios with constant
//   expectations, then randomized traffic against a period-level model.
// -----------------------------------------------------------------------------
module tb_frac_baud_gen;
    import baud_pkg::*;

    localparam int unsigned CW      = 16;
    localparam int unsigned FW      = 4;
    localparam int unsigned OVS     = 16;
    localparam int unsigned DIV_RST = 326;
`ifdef FRAC_BAUD_GEN_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    frac_baud_gen_if #(.CW(CW), .FW(FW), .OVS(OVS)) bus ();

    frac_baud_gen #(.CW(CW), .FW(FW), .OVS(OVS), .DIV_RST(DIV_RST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (one period at a time) ----------------
    int m_int, m_frac, m_sh_int, m_sh_frac, m_pend;
    int m_elapsed, m_acc, m_carry, m_phase;
    int e_tick, e_bit, e_ack;

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_int = DIV_RST; m_frac = 0; m_sh_int = 0; m_sh_frac = 0; m_pend = 0;
        m_elapsed = 0; m_acc = 0; m_carry = 0; m_phase = 0;
        e_tick = 0; e_bit = 0; e_ack = 0;
    endtask

    task automatic model_apply();
        m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; e_ack = 1;
    endtask

    task automatic model_update();
        int len;
        e_tick = 0; e_bit = 0; e_ack = 0;
        if (bus.clr) begin
            m_elapsed = 0; m_acc = 0; m_carry = 0; m_phase = 0;
        end else if (!bus.en) begin
            if (m_pend != 0) model_apply();
        end else begin
            m_elapsed++;
            len = max1(m_int) + m_carry;
            if (m_elapsed >= len) begin
                m_elapsed = 0;
                e_tick    = 1;
                m_phase   = (m_phase + 1) % OVS;
                e_bit     = (m_phase == 0);
                if (m_pend != 0) model_apply();
                if (FRAC) begin
                    m_acc   = m_acc + m_frac;
                    m_carry = m_acc / 16;
                    m_acc   = m_acc % 16;
                end
            end
        end
        if (bus.div_wr) begin
            m_sh_int = bus.div_int; m_sh_frac = bus.div_frac; m_pend = 1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_update();
        #1;
    endtask

    task automatic write_div(input int di, input int df);
        bus.div_int  = CW'(di);
        bus.div_frac = FW'(df);
        bus.div_wr   = 1'b1;
        step();
        bus.div_wr   = 1'b0;
    endtask

    task automatic wait_ack(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (bus.div_ack === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // phase < 0 means any tick
    task automatic wait_tick(input int phase, input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (bus.tick === 1'b1 && (phase < 0 || int'(bus.ovs_phase) == phase)) begin
                ok = 1'b1; break;
            end
        end
    endtask

    task automatic cycles_to_tick(input int bound, output int n);
        n = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (bus.tick === 1'b1) begin n = i; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0; bus.clr = 1'b0; bus.div_wr = 1'b0;
        bus.div_int = '0; bus.div_frac = '0;
        model_reset();
        step(); step();
        n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
        n_cmp++; if (bus.bit_tick !== 1'b0) begin n_bad++; $display("FAIL reset_bit_tick: got %b want 0", bus.bit_tick); end
        n_cmp++; if (bus.ovs_phase !== 4'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", bus.ovs_phase); end
        n_cmp++; if (bus.div_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.div_ack); end
        rst = 1'b0;
    endtask

    task automatic test_default();
        int cyc, last, ticks;
        cyc = 0; last = 0; ticks = 0;
        bus.en = 1'b1;
        while (ticks < 16 && cyc < 5400) begin
            step(); cyc++;
            if (bus.tick === 1'b1) begin
                ticks++;
                n_cmp++; if (cyc - last != 326) begin n_bad++; $display("FAIL default_period: got %0d want 326", cyc - last); end
                n_cmp++; if (int'(bus.ovs_phase) != ticks % 16) begin n_bad++; $display("FAIL default_phase: got %0d want %0d", bus.ovs_phase, ticks % 16); end
                n_cmp++; if (bus.bit_tick !== ((ticks % 16) == 0)) begin n_bad++; $display("FAIL default_bit_tick: got %b want %b", bus.bit_tick, (ticks % 16) == 0); end
                last = cyc;
            end
        end
        n_cmp++; if (ticks != 16) begin n_bad++; $display("FAIL default_tick_count: got %0d want 16", ticks); end
        n_cmp++; if (last != 5216) begin n_bad++; $display("FAIL default_bit_time: got %0d want 5216", last); end
    endtask

    task automatic test_frac();
        div_t d;
        logic ok;
        int   cyc, last, ticks, want;
        d = calc_div(64'd19_353_600, 64'd115_200, 64'd16);
        n_cmp++; if (d.div_int !== 16'd10) begin n_bad++; $display("FAIL calc_div_int: got %0d want 10", d.div_int); end
        n_cmp++; if (d.div_frac !== 4'd8) begin n_bad++; $display("FAIL calc_div_frac: got %0d want 8", d.div_frac); end
        write_div(10, 8);
        wait_ack(400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL frac_ack_timeout: got %b want 1", ok); end
        n_cmp++; if (bus.tick !== 1'b1) begin n_bad++; $display("FAIL frac_ack_with_tick: got %b want 1", bus.tick); end
        cyc = 0; last = 0; ticks = 0;
        while (ticks < 16 && cyc < 250) begin
            step(); cyc++;
            if (bus.tick === 1'b1) begin
                ticks++;
                want = (FRAC && (ticks % 2) == 0) ? 11 : 10;
                n_cmp++; if (cyc - last != want) begin n_bad++; $display("FAIL frac_period: got %0d want %0d", cyc - last, want); end
                last = cyc;
            end
        end
        want = FRAC ? 168 : 160;
        n_cmp++; if (last != want || ticks != 16) begin n_bad++; $display("FAIL frac_16_ticks: got %0d cycles/%0d ticks want %0d/16", last, ticks, want); end
    endtask

    task automatic test_update_mid();
        logic ok;
        int   n;
        write_div(10, 0);
        wait_ack(40, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL upd_first_ack: got %b want 1", ok); end
        step(); step(); step();
        write_div(20, 0);
        cycles_to_tick(20, n);
        n_cmp++; if (n + 4 != 10) begin n_bad++; $display("FAIL upd_current_period: got %0d want 10", n + 4); end
        n_cmp++; if (bus.div_ack !== 1'b1) begin n_bad++; $display("FAIL upd_ack: got %b want 1", bus.div_ack); end
        cycles_to_tick(40, n);
        n_cmp++; if (n != 20) begin n_bad++; $display("FAIL upd_new_period: got %0d want 20", n); end
        n_cmp++; if (bus.div_ack !== 1'b0) begin n_bad++; $display("FAIL upd_ack_once: got %b want 0", bus.div_ack); end
    endtask

    task automatic test_clr();
        logic ok;
        int   n;
        write_div(10, 0);
        wait_ack(40, ok);
        wait_tick(7, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL clr_find_phase7: got %b want 1", ok); end
        for (int i = 0; i < 5; i++) step();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL clr_tick: got %b want 0", bus.tick); end
        n_cmp++; if (bus.ovs_phase !== 4'd0) begin n_bad++; $display("FAIL clr_phase: got %0d want 0", bus.ovs_phase); end
        cycles_to_tick(30, n);
        n_cmp++; if (n != 10) begin n_bad++; $display("FAIL clr_restart: got %0d want 10", n); end
        n_cmp++; if (bus.ovs_phase !== 4'd1) begin n_bad++; $display("FAIL clr_phase_after: got %0d want 1", bus.ovs_phase); end
    endtask

    task automatic test_en_hold();
        logic ok;
        int   n, held_ticks, phase0;
        wait_tick(-1, 20, ok);
        for (int i = 0; i < 4; i++) step();
        phase0 = int'(bus.ovs_phase);
        bus.en = 1'b0;
        held_ticks = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.tick !== 1'b0 || int'(bus.ovs_phase) != phase0) held_ticks++;
        end
        n_cmp++; if (held_ticks != 0) begin n_bad++; $display("FAIL hold_activity: got %0d want 0", held_ticks); end
        bus.en = 1'b1;
        cycles_to_tick(30, n);
        n_cmp++; if (n != 6) begin n_bad++; $display("FAIL hold_resume: got %0d want 6", n); end
    endtask

    task automatic test_min_div();
        logic ok;
        int   ticks, bits;
        for (int v = 0; v < 2; v++) begin
            write_div(v, 0);
            wait_ack(40, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL min_ack div=%0d: got %b want 1", v, ok); end
            ticks = 0; bits = 0;
            for (int i = 0; i < 32; i++) begin
                step();
                if (bus.tick === 1'b1) ticks++;
                if (bus.bit_tick === 1'b1) bits++;
            end
            n_cmp++; if (ticks != 32) begin n_bad++; $display("FAIL min_ticks div=%0d: got %0d want 32", v, ticks); end
            n_cmp++; if (bits != 2) begin n_bad++; $display("FAIL min_bits div=%0d: got %0d want 2", v, bits); end
        end
    endtask

    task automatic test_async_reset();
        logic ok;
        int   n;
        write_div(10, 0);
        wait_ack(40, ok);
        wait_tick(3, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL arst_find_phase3: got %b want 1", ok); end
        write_div(50, 0);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (bus.ovs_phase !== 4'd0) begin n_bad++; $display("FAIL arst_phase: got %0d want 0", bus.ovs_phase); end
        n_cmp++; if (bus.tick !== 1'b0 || bus.bit_tick !== 1'b0 || bus.div_ack !== 1'b0) begin
            n_bad++; $display("FAIL arst_outputs: got %b%b%b want 000", bus.tick, bus.bit_tick, bus.div_ack);
        end
        step(); step();
        rst = 1'b0;
        cycles_to_tick(800, n);
        n_cmp++; if (n != 326) begin n_bad++; $display("FAIL arst_first_period: got %0d want 326", n); end
        cycles_to_tick(800, n);
        n_cmp++; if (n != 326) begin n_bad++; $display("FAIL arst_shadow_discarded: got %0d want 326", n); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            bus.en       = ($urandom_range(0, 9) != 0);
            bus.clr      = ($urandom_range(0, 99) == 0);
            bus.div_wr   = ($urandom_range(0, 29) == 0);
            bus.div_int  = CW'($urandom_range(0, 12));
            bus.div_frac = FW'($urandom_range(0, 15));
            step();
            n_cmp++; if (bus.tick !== e_tick[0]) begin n_bad++; $display("FAIL rnd_tick @%0d: got %b want %0d", i, bus.tick, e_tick); end
            n_cmp++; if (bus.bit_tick !== e_bit[0]) begin n_bad++; $display("FAIL rnd_bit_tick @%0d: got %b want %0d", i, bus.bit_tick, e_bit); end
            n_cmp++; if (int'(bus.ovs_phase) != m_phase) begin n_bad++; $display("FAIL rnd_phase @%0d: got %0d want %0d", i, bus.ovs_phase, m_phase); end
            n_cmp++; if (bus.div_ack !== e_ack[0]) begin n_bad++; $display("FAIL rnd_ack @%0d: got %b want %0d", i, bus.div_ack, e_ack); end
        end
        bus.clr = 1'b0; bus.div_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_frac();
        test_update_mid();
        test_clr();
        test_en_hold();
        test_min_div();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
